eth_fcs_tx: RTL and testbench

- Transmit-side Ethernet framer; the counterpart to the receive path's CRC checker.
- Accepts a byte stream (dest MAC .. payload) and emits it with preamble/SFD prepended.
- Pads the frame with zeros to the minimum length and appends the 4-byte CRC-32 FCS.
- Enforces the inter-frame gap before the next frame is accepted.
- Sits between the UDP/IP frame builder and the MAC/PHY byte interface.

---
 rtl/eth_pkg.sv | 38 +++
 rtl/eth_tx_crc32.sv | 29 ++
 rtl/eth_fcs_tx.sv | 173 +++++++++++++++++
 tb/tb_eth_fcs_tx.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit framer.
//   - CRC-32 constants (init value and good-frame residue)
//   - preamble / start-of-frame-delimiter byte values
//   - tx_state_t: framer state encoding
//   - next_crc32_d8: one-byte update of the reflected CRC-32 (poly 0xEDB88320)
package eth_pkg;

    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] CRC32_POLY_R  = 32'hEDB8_8320;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_PAD,
        S_FCS,
        S_IFG
    } tx_state_t;

    // Reflected CRC-32: the data byte enters LSB first, so the register
    // shifts right and the polynomial is applied in bit-reversed form.
    function automatic logic [31:0] next_crc32_d8(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) begin
                r = (r >> 1) ^ CRC32_POLY_R;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_tx_crc32.sv
// Running CRC-32 register for the transmit framer.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (reset loads the init value)
//   init         reload CRC32_INIT (wins over en)
//   en           fold byte_in into the running CRC
//   byte_in      data byte to accumulate
//   crc          current (non-inverted) CRC register
module eth_tx_crc32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  byte_in,
    output logic [31:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= CRC32_INIT;
        end else if (init) begin
            crc <= CRC32_INIT;
        end else if (en) begin
            crc <= next_crc32_d8(crc, byte_in);
        end
    end

endmodule

// File: rtl/eth_fcs_tx.sv
// Transmit-side Ethernet framer: prepends preamble/SFD, passes the frame
// through, zero-pads to MIN_FRAME bytes, appends the CRC-32 FCS (LSB byte
// first) and then holds off the next frame for IFG_CYCLES idle cycles.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   s_data/s_valid/s_last/s_ready input byte stream (dest MAC .. payload)
//   m_data/m_valid/m_last/m_ready output byte stream (m_last on final FCS byte)
//   busy                          high whenever the framer is not idle
//   frame_done                    pulse in the cycle the final FCS byte is accepted
module eth_fcs_tx
    import eth_pkg::*;
#(
    parameter int MIN_FRAME   = 60,
    parameter int IFG_CYCLES  = 12,
    parameter int PREAMBLE_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [16:0] MIN_LEN  = 17'(MIN_FRAME);
    // Last count value of the gap; a zero gap still spends one cycle in IFG.
    localparam logic [15:0] IFG_LAST = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

    tx_state_t   state_reg, state_next;
    // Shared phase counter: preamble beat, FCS byte index or gap cycle.
    logic [15:0] cnt_reg, cnt_next;
    logic [15:0] byte_cnt_reg, byte_cnt_next;
    logic [15:0] byte_cnt_sat;
    logic [16:0] byte_cnt_plus1;

    logic        crc_init, crc_en;
    logic [7:0]  crc_byte;
    logic [31:0] crc_value;
    logic [31:0] fcs;

    eth_tx_crc32 u_crc (
        .clk     (clk),
        .rst     (rst),
        .init    (crc_init),
        .en      (crc_en),
        .byte_in (crc_byte),
        .crc     (crc_value)
    );

    // The CRC register is frozen while in FCS, so its complement is the
    // value captured at FCS entry.
    assign fcs            = ~crc_value;
    assign byte_cnt_plus1 = {1'b0, byte_cnt_reg} + 17'd1;
    assign byte_cnt_sat   = (byte_cnt_reg == 16'hFFFF) ? byte_cnt_reg : byte_cnt_reg + 16'd1;
    assign busy           = (state_reg != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= 16'd0;
            byte_cnt_reg <= 16'd0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            byte_cnt_reg <= byte_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        m_data        = 8'h00;
        m_valid       = 1'b0;
        m_last        = 1'b0;
        s_ready       = 1'b0;
        frame_done    = 1'b0;
        crc_init      = 1'b0;
        crc_en        = 1'b0;
        crc_byte      = 8'h00;

        case (state_reg)
            S_IDLE: begin
                if (s_valid) begin
                    crc_init      = 1'b1;
                    byte_cnt_next = 16'd0;
                    cnt_next      = 16'd0;
                    state_next    = (PREAMBLE_EN != 0) ? S_PREAMBLE : S_DATA;
                end
            end

            S_PREAMBLE: begin
                m_valid = 1'b1;
                m_data  = (cnt_reg[2:0] == 3'd7) ? SFD_BYTE : PREAMBLE_BYTE;
                if (m_ready) begin
                    if (cnt_reg[2:0] == 3'd7) begin
                        cnt_next   = 16'd0;
                        state_next = S_DATA;
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
            end

            S_DATA: begin
                m_data   = s_data;
                m_valid  = s_valid;
                s_ready  = m_ready;
                crc_byte = s_data;
                if (s_valid && m_ready) begin
                    crc_en        = 1'b1;
                    byte_cnt_next = byte_cnt_sat;
                    if (s_last) begin
                        cnt_next   = 16'd0;
                        state_next = (byte_cnt_plus1 < MIN_LEN) ? S_PAD : S_FCS;
                    end
                end
            end

            S_PAD: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    crc_en        = 1'b1;
                    byte_cnt_next = byte_cnt_sat;
                    if (byte_cnt_plus1 >= MIN_LEN) begin
                        cnt_next   = 16'd0;
                        state_next = S_FCS;
                    end
                end
            end

            S_FCS: begin
                m_valid = 1'b1;
                m_last  = (cnt_reg[1:0] == 2'd3);
                case (cnt_reg[1:0])
                    2'd0:    m_data = fcs[7:0];
                    2'd1:    m_data = fcs[15:8];
                    2'd2:    m_data = fcs[23:16];
                    default: m_data = fcs[31:24];
                endcase
                if (m_ready) begin
                    if (cnt_reg[1:0] == 2'd3) begin
                        frame_done = 1'b1;
                        cnt_next   = 16'd0;
                        state_next = S_IFG;
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
            end

            S_IFG: begin
                if (cnt_reg >= IFG_LAST) begin
                    cnt_next   = 16'd0;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_eth_fcs_tx.sv
// Self-checking bench for eth_fcs_tx: a padded/preamble instance driven with
// random frames and random stalls, plus a bare instance checked against the
// standard "123456789" CRC-32 vector.
module tb_eth_fcs_tx;

    localparam int MIN_FRAME  = 60;
    localparam int IFG_CYCLES = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: MIN_FRAME=60, preamble on
    logic [7:0] s_data  = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last  = 1'b0;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid, m_last;
    logic       m_ready = 1'b1;
    logic       busy, frame_done;

    // Instance B: no padding, no preamble
    logic [7:0] s_data_b  = 8'h00;
    logic       s_valid_b = 1'b0;
    logic       s_last_b  = 1'b0;
    logic       s_ready_b;
    logic [7:0] m_data_b;
    logic       m_valid_b, m_last_b;
    logic       m_ready_b = 1'b1;
    logic       busy_b, frame_done_b;

    eth_fcs_tx #(.MIN_FRAME(MIN_FRAME), .IFG_CYCLES(IFG_CYCLES), .PREAMBLE_EN(1)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .frame_done(frame_done)
    );

    eth_fcs_tx #(.MIN_FRAME(0), .IFG_CYCLES(IFG_CYCLES), .PREAMBLE_EN(0)) dut_b (
        .clk(clk), .rst(rst),
        .s_data(s_data_b), .s_valid(s_valid_b), .s_last(s_last_b), .s_ready(s_ready_b),
        .m_data(m_data_b), .m_valid(m_valid_b), .m_last(m_last_b), .m_ready(m_ready_b),
        .busy(busy_b), .frame_done(frame_done_b)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] frame_q[$];
    logic [7:0] exp_q[$];
    logic       exp_last_q[$];
    logic [7:0] out_q[$];
    logic       last_q[$];
    logic [7:0] save_q[$];
    logic [7:0] out_b_q[$];
    logic       last_b_q[$];

    int   done_cnt   = 0;
    int   done_b_cnt = 0;
    int   gap_cnt    = 0;
    int   last_gap   = -1;
    bit   gap_arm    = 1'b0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit   stall_en   = 1'b0;

    // Output ready: random back-pressure while stall_en is set.
    always @(posedge clk) begin
        #1;
        m_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Monitor: collects accepted bytes, checks stability under back-pressure,
    // the frame_done qualification and the quiet gap after each frame.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                total++;
                assert ({m_valid, m_data} === {1'b1, prev_data})
                else begin
                    bad++;
                    $error("FAIL hold_stable got=%b/%h exp=1/%h", m_valid, m_data, prev_data);
                end
            end
            if (frame_done) begin
                total++;
                assert ({m_valid, m_ready, m_last} === 3'b111)
                else begin
                    bad++;
                    $error("FAIL done_qual got=%b exp=111", {m_valid, m_ready, m_last});
                end
                done_cnt++;
            end
            if (m_valid && m_ready) begin
                out_q.push_back(m_data);
                last_q.push_back(m_last);
            end
            if (gap_arm && m_valid) begin
                last_gap = gap_cnt;
                gap_arm  = 1'b0;
            end else if (gap_arm) begin
                gap_cnt++;
            end
            if (frame_done) begin
                gap_arm = 1'b1;
                gap_cnt = 0;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;

            if (m_valid_b && m_ready_b) begin
                out_b_q.push_back(m_data_b);
                last_b_q.push_back(m_last_b);
            end
            if (frame_done_b) done_b_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Plain bit-serial CRC-32 as defined for Ethernet (LSB first, reflected poly).
    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    task automatic make_frame(input int len);
        frame_q.delete();
        for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
    endtask

    // Appends the expected wire image of frame_q to exp_q/exp_last_q.
    task automatic build_expected();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 7; i++) begin exp_q.push_back(8'h55); exp_last_q.push_back(1'b0); end
        exp_q.push_back(8'hD5); exp_last_q.push_back(1'b0);
        foreach (frame_q[i]) begin
            exp_q.push_back(frame_q[i]); exp_last_q.push_back(1'b0);
            c = ref_crc(c, frame_q[i]);
        end
        for (int i = frame_q.size(); i < MIN_FRAME; i++) begin
            exp_q.push_back(8'h00); exp_last_q.push_back(1'b0);
            c = ref_crc(c, 8'h00);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(c[8*k +: 8]);
            exp_last_q.push_back(k == 3);
        end
    endtask

    // Drives frame_q on the input side; s_valid drops randomly when stalling,
    // but a presented byte is held until accepted.
    task automatic send_frame(input bit stall);
        int   i, guard;
        logic hs;
        i = 0; guard = 0;
        @(posedge clk); #1;
        s_valid = !stall || ($urandom_range(0, 3) != 0);
        s_data  = frame_q[0];
        s_last  = (frame_q.size() == 1);
        while (i < frame_q.size() && guard < 20000) begin
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk); #1;
            guard++;
            if (hs) i++;
            if (i < frame_q.size()) begin
                if (hs || !s_valid) begin
                    s_valid = !stall || ($urandom_range(0, 3) != 0);
                    s_data  = frame_q[i];
                    s_last  = (i == frame_q.size() - 1);
                end
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        total++;
        assert (guard < 20000)
        else begin bad++; $error("FAIL send_timeout got=%0d exp<%0d", guard, 20000); end
    endtask

    task automatic wait_done(input int target, input string tag);
        int guard;
        guard = 0;
        while (done_cnt < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        repeat (IFG_CYCLES + 4) @(negedge clk);
        total++;
        assert (done_cnt === target)
        else begin bad++; $error("FAIL %s_done got=%0d exp=%0d", tag, done_cnt, target); end
        total++;
        assert (busy === 1'b0)
        else begin bad++; $error("FAIL %s_idle got=%b exp=0", tag, busy); end
    endtask

    task automatic check_out(input string tag, input bit do_res);
        int          errs, first, lerrs;
        logic [31:0] r;
        errs = 0; first = -1; lerrs = 0;
        total++;
        assert (out_q.size() === exp_q.size())
        else begin bad++; $error("FAIL %s_len got=%0d exp=%0d", tag, out_q.size(), exp_q.size()); end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            if (out_q[i] !== exp_q[i]) begin
                if (first < 0) first = i;
                errs++;
            end
            if (last_q[i] !== exp_last_q[i]) lerrs++;
        end
        total++;
        assert (errs === 0)
        else begin bad++; $error("FAIL %s_bytes got=%0d_bad(first %0d) exp=0", tag, errs, first); end
        total++;
        assert (lerrs === 0)
        else begin bad++; $error("FAIL %s_mlast got=%0d_bad exp=0", tag, lerrs); end
        if (do_res) begin
            r = 32'hFFFFFFFF;
            for (int i = 8; i < out_q.size(); i++) r = ref_crc(r, out_q[i]);
            total++;
            assert (r === 32'hDEBB20E3)
            else begin bad++; $error("FAIL %s_residue got=%h exp=%h", tag, r, 32'hDEBB20E3); end
        end
        $display("frame %s: beats=%0d expected=%0d byte_errors=%0d", tag, out_q.size(), exp_q.size(), errs);
    endtask

    task automatic clear_q();
        out_q.delete(); last_q.delete(); exp_q.delete(); exp_last_q.delete();
    endtask

    task automatic run_frame(input int len, input bit stall, input string tag);
        int base;
        base = done_cnt;
        make_frame(len);
        build_expected();
        stall_en = stall;
        send_frame(stall);
        wait_done(base + 1, tag);
        stall_en = 1'b0;
        check_out(tag, 1'b1);
    endtask

    initial begin
        int   i, guard, base;
        logic hs;
        logic [7:0] kv_exp[13];

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        total++;
        assert ({m_valid, m_last, s_ready, busy, frame_done} === 5'b0)
        else begin bad++; $error("FAIL reset_ctrl got=%b exp=00000", {m_valid, m_last, s_ready, busy, frame_done}); end
        total++;
        assert (m_data === 8'h00)
        else begin bad++; $error("FAIL reset_mdata got=%h exp=00", m_data); end
        total++;
        assert ({m_valid_b, s_ready_b, busy_b} === 3'b0)
        else begin bad++; $error("FAIL reset_b got=%b exp=000", {m_valid_b, s_ready_b, busy_b}); end
        $display("reset: m_valid=%b s_ready=%b busy=%b m_data=%h", m_valid, s_ready, busy, m_data);
        @(posedge clk); #1;
        rst = 1'b0;

        // Standard check vector on the bare instance
        for (int k = 0; k < 9; k++) kv_exp[k] = 8'h31 + 8'(k);
        kv_exp[9] = 8'h26; kv_exp[10] = 8'h39; kv_exp[11] = 8'hF4; kv_exp[12] = 8'hCB;
        i = 0; guard = 0;
        s_valid_b = 1'b1; s_data_b = 8'h31; s_last_b = 1'b0;
        while (i < 9 && guard < 200) begin
            @(negedge clk);
            hs = s_valid_b && s_ready_b;
            @(posedge clk); #1;
            guard++;
            if (hs) i++;
            if (i < 9) begin
                s_data_b = 8'h31 + 8'(i);
                s_last_b = (i == 8);
            end else begin
                s_valid_b = 1'b0;
                s_last_b  = 1'b0;
            end
        end
        repeat (IFG_CYCLES + 10) @(negedge clk);
        total++;
        assert (out_b_q.size() === 13)
        else begin bad++; $error("FAIL kv_len got=%0d exp=13", out_b_q.size()); end
        for (int k = 0; k < 13 && k < out_b_q.size(); k++) begin
            total++;
            assert ({out_b_q[k], last_b_q[k]} === {kv_exp[k], (k == 12)})
            else begin bad++; $error("FAIL kv_byte%0d got=%h/%b exp=%h/%b", k, out_b_q[k], last_b_q[k], kv_exp[k], (k == 12)); end
        end
        total++;
        assert (done_b_cnt === 1)
        else begin bad++; $error("FAIL kv_done got=%0d exp=1", done_b_cnt); end
        $display("frame kv: beats=%0d done_pulses=%0d", out_b_q.size(), done_b_cnt);

        // Short frame: 46 bytes of padding
        run_frame(14, 1'b0, "pad14");
        clear_q();
        // Exactly above the minimum: no padding
        run_frame(64, 1'b0, "len64");
        total++;
        assert (exp_q.size() === 76)
        else begin bad++; $error("FAIL len64_model got=%0d exp=76", exp_q.size()); end
        clear_q();

        // Same 100-byte frame without and with stalls
        make_frame(100);
        build_expected();
        base = done_cnt;
        send_frame(1'b0);
        wait_done(base + 1, "nostall100");
        check_out("nostall100", 1'b1);
        save_q = out_q;
        out_q.delete(); last_q.delete();
        stall_en = 1'b1;
        base = done_cnt;
        send_frame(1'b1);
        wait_done(base + 1, "stall100");
        stall_en = 1'b0;
        check_out("stall100", 1'b1);
        total++;
        assert (out_q === save_q)
        else begin bad++; $error("FAIL stall_vs_nostall got=%0d_beats exp=%0d_beats", out_q.size(), save_q.size()); end
        clear_q();

        // Back-to-back frames: gap between frame_done and next preamble
        base = done_cnt;
        make_frame(20);
        build_expected();
        send_frame(1'b0);
        make_frame(70);
        build_expected();
        send_frame(1'b0);
        wait_done(base + 2, "b2b");
        check_out("b2b", 1'b0);
        total++;
        assert (last_gap === IFG_CYCLES + 1)
        else begin bad++; $error("FAIL ifg_gap got=%0d exp=%0d", last_gap, IFG_CYCLES + 1); end
        $display("ifg gap: %0d idle cycles", last_gap);
        clear_q();

        // Reset in the middle of DATA
        s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b0;
        guard = 0;
        while (out_q.size() < 12 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        #1;
        rst = 1'b1;
        #1;
        total++;
        assert ({m_valid, m_last, s_ready, busy, frame_done, m_data} === 13'b0)
        else begin bad++; $error("FAIL midreset got=%b/%h exp=00000/00", {m_valid, m_last, s_ready, busy, frame_done}, m_data); end
        $display("reset mid-frame after %0d beats: busy=%b m_valid=%b", out_q.size(), busy, m_valid);
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_q();
        run_frame(30, 1'b0, "after_rst");
        clear_q();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
